// File: rtl/perf_region_pkg.sv
`default_nettype none
// ============================================================================
// Module  : perf_region_pkg
// Brief   : Register map, CTRL field positions and FSM encoding shared by the
//           performance-region profiler.
// Rev     : 1.0  initial release
// ============================================================================
package perf_region_pkg;

    localparam logic [7:0] c_ctrl_off      = 8'h00;
    localparam logic [7:0] c_ovf_off       = 8'h04;
    localparam logic [7:0] c_clear_off     = 8'h08;
    localparam logic [7:0] c_region_base   = 8'h10;
    localparam logic [7:0] c_region_stride = 8'h10;

    localparam int c_ctrl_start_bit  = 0;
    localparam int c_ctrl_stop_bit   = 1;
    localparam int c_ctrl_region_lsb = 4;
    localparam int c_ctrl_region_w   = 3;

    // Word selectors inside one region's 16-byte window
    localparam logic [1:0] c_reg_cyc_lo  = 2'd0;
    localparam logic [1:0] c_reg_cyc_hi  = 2'd1;
    localparam logic [1:0] c_reg_instr   = 2'd2;
    localparam logic [1:0] c_reg_entries = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/perf_region_counter.sv
`default_nettype none
// ============================================================================
// Module  : perf_region_counter
// Brief   : Cycle / retired-instruction / entry accumulators and sticky
//           overflow flag for a single profiled region.
// Rev     : 1.0  initial release
// ============================================================================
module perf_region_counter #(
    parameter int CYCLE_CNT_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_inc_cyc,
    input  logic                       i_inc_instr,
    input  logic                       i_inc_entry,
    input  logic                       i_clear,
    input  logic                       i_ovf_clr,
    output logic [CYCLE_CNT_WIDTH-1:0] o_cycles,
    output logic [31:0]                o_instr,
    output logic [31:0]                o_entries,
    output logic                       o_ovf
);

    logic [CYCLE_CNT_WIDTH-1:0] r_cycles;
    logic [31:0]                r_instr;
    logic [31:0]                r_entries;
    logic                       r_ovf;
    logic                       w_wrap;

    assign w_wrap = (i_inc_cyc   && (&r_cycles))
                 || (i_inc_instr && (&r_instr))
                 || (i_inc_entry && (&r_entries));

    // Clear dominates every increment; a wrap beats a same-cycle ovf clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles  <= '0;
            r_instr   <= '0;
            r_entries <= '0;
            r_ovf     <= 1'b0;
        end else if (i_clear) begin
            r_cycles  <= '0;
            r_instr   <= '0;
            r_entries <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (i_inc_cyc)   r_cycles  <= r_cycles + CYCLE_CNT_WIDTH'(1);
            if (i_inc_instr) r_instr   <= r_instr + 32'd1;
            if (i_inc_entry) r_entries <= r_entries + 32'd1;
            if (w_wrap)         r_ovf <= 1'b1;
            else if (i_ovf_clr) r_ovf <= 1'b0;
        end
    end

    assign o_cycles  = r_cycles;
    assign o_instr   = r_instr;
    assign o_entries = r_entries;
    assign o_ovf     = r_ovf;

endmodule
`default_nettype wire

// File: rtl/perf_region_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : perf_region_ctrl
// Brief   : Bus-mapped code-region profiler; firmware opens/closes regions and
//           reads back per-region cycle, instruction and entry counts.
// Rev     : 1.0  initial release
// ============================================================================
module perf_region_ctrl
    import perf_region_pkg::*;
#(
    parameter int NUM_REGIONS     = 4,
    parameter int CYCLE_CNT_WIDTH = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic        instret_i,
    output logic        busy_o
);

    localparam int c_hi_w = CYCLE_CNT_WIDTH - 32;

    logic                       w_wr_ok;
    logic                       w_rd;
    logic                       w_hit_ctrl;
    logic                       w_hit_ovf;
    logic                       w_hit_clear;
    logic                       w_hit_region;
    logic [7:0]                 w_rel;
    logic [3:0]                 w_idx;
    logic [1:0]                 w_sel;
    logic [2:0]                 w_region;
    logic                       w_start;
    logic                       w_stop;
    logic                       w_region_ok;
    logic                       w_start_ok;
    logic                       w_clear;
    logic                       w_counting;
    logic                       w_hi_load;
    logic [c_hi_w-1:0]          w_hi_next;
    logic [31:0]                w_rdata;
    logic                       w_unused;

    logic [CYCLE_CNT_WIDTH-1:0] w_cycles  [NUM_REGIONS];
    logic [31:0]                w_instr   [NUM_REGIONS];
    logic [31:0]                w_entries [NUM_REGIONS];
    logic [NUM_REGIONS-1:0]     w_ovf;
    logic [NUM_REGIONS-1:0]     w_inc_cyc;
    logic [NUM_REGIONS-1:0]     w_inc_instr;
    logic [NUM_REGIONS-1:0]     w_inc_entry;
    logic [NUM_REGIONS-1:0]     w_ovf_clr;

    state_e                     r_state;
    logic [2:0]                 r_active;
    logic                       r_rvalid;
    logic [31:0]                r_rdata;
    logic [c_hi_w-1:0]          r_cyc_hi;

    assign w_wr_ok     = req_i && we_i && (be_i == 4'hF);
    assign w_rd        = req_i && !we_i;
    assign w_hit_ctrl  = (addr_i[7:2] == c_ctrl_off[7:2]);
    assign w_hit_ovf   = (addr_i[7:2] == c_ovf_off[7:2]);
    assign w_hit_clear = (addr_i[7:2] == c_clear_off[7:2]);

    assign w_rel        = addr_i[7:0] - c_region_base;
    assign w_idx        = 4'(w_rel / c_region_stride);
    assign w_sel        = w_rel[3:2];
    assign w_hit_region = (addr_i[7:0] >= c_region_base) && (w_idx < 4'(NUM_REGIONS));

    assign w_region    = wdata_i[c_ctrl_region_lsb +: c_ctrl_region_w];
    assign w_start     = w_wr_ok && w_hit_ctrl && wdata_i[c_ctrl_start_bit];
    assign w_stop      = w_wr_ok && w_hit_ctrl && wdata_i[c_ctrl_stop_bit];
    assign w_region_ok = ({1'b0, w_region} < 4'(NUM_REGIONS));
    assign w_start_ok  = w_start && !w_stop && w_region_ok;
    assign w_clear     = w_wr_ok && w_hit_clear;

    // A region switch leaves a one-cycle gap; a STOP cycle is still counted
    assign w_counting  = (r_state == ST_RUN) && !w_start_ok;

    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
        assign w_inc_cyc[r]   = w_counting && (r_active == 3'(r));
        assign w_inc_instr[r] = w_inc_cyc[r] && instret_i;
        assign w_inc_entry[r] = w_start_ok && (w_region == 3'(r));
        assign w_ovf_clr[r]   = w_wr_ok && w_hit_ovf && wdata_i[r];

        perf_region_counter #(
            .CYCLE_CNT_WIDTH (CYCLE_CNT_WIDTH)
        ) u_counter (
            .clk         (clk_i),
            .rst_n       (rst_ni),
            .i_inc_cyc   (w_inc_cyc[r]),
            .i_inc_instr (w_inc_instr[r]),
            .i_inc_entry (w_inc_entry[r]),
            .i_clear     (w_clear),
            .i_ovf_clr   (w_ovf_clr[r]),
            .o_cycles    (w_cycles[r]),
            .o_instr     (w_instr[r]),
            .o_entries   (w_entries[r]),
            .o_ovf       (w_ovf[r])
        );
    end

    assign w_hi_load = w_rd && w_hit_region && (w_sel == c_reg_cyc_lo);

    always_comb begin
        w_rdata   = '0;
        w_hi_next = '0;
        if (w_hit_ctrl) begin
            w_rdata[c_ctrl_start_bit]                          = (r_state == ST_RUN);
            w_rdata[c_ctrl_region_lsb +: c_ctrl_region_w]      = r_active;
        end else if (w_hit_ovf) begin
            w_rdata = 32'(w_ovf);
        end else if (w_hit_region) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                if (w_idx == 4'(r)) begin
                    w_hi_next = w_cycles[r][CYCLE_CNT_WIDTH-1:32];
                    case (w_sel)
                        c_reg_cyc_lo:  w_rdata = w_cycles[r][31:0];
                        c_reg_cyc_hi:  w_rdata = 32'(r_cyc_hi);
                        c_reg_instr:   w_rdata = w_instr[r];
                        c_reg_entries: w_rdata = w_entries[r];
                        default:       w_rdata = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_active <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_cyc_hi <= '0;
        end else begin
            r_rvalid <= req_i;
            if (req_i) r_rdata <= w_rd ? w_rdata : 32'h0;
            if (w_hi_load) r_cyc_hi <= w_hi_next;

            if (w_clear) begin
                r_state  <= ST_IDLE;
                r_active <= '0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
            end else if (w_start_ok) begin
                r_state  <= ST_RUN;
                r_active <= w_region;
            end
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign busy_o   = (r_state == ST_RUN);

    assign w_unused = ^{addr_i[31:8], wdata_i, w_rel[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_perf_region_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_perf_region_ctrl
// Brief   : Directed scoreboard bench for the performance-region profiler.
// Rev     : 1.0  initial release
// ============================================================================
module tb_perf_region_ctrl;

    logic        clk       = 1'b0;
    logic        rst_ni    = 1'b0;
    logic        req_i     = 1'b0;
    logic        we_i      = 1'b0;
    logic [3:0]  be_i      = 4'h0;
    logic [31:0] addr_i    = 32'h0;
    logic [31:0] wdata_i   = 32'h0;
    logic        instret_i = 1'b0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        busy_o;

    typedef struct {
        string       tag;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    logic prev_req;

    perf_region_ctrl #(
        .NUM_REGIONS     (4),
        .CYCLE_CNT_WIDTH (64)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .we_i      (we_i),
        .be_i      (be_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .instret_i (instret_i),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) prev_req <= 1'b0;
        else         prev_req <= req_i;
    end

    // Response monitor: rvalid exactly one cycle after req, data from scoreboard
    always @(negedge clk) begin
        if (rst_ni && (prev_req || rvalid_o)) begin
            checks++;
            assert (rvalid_o === prev_req) else begin
                errors++;
                $error("FAIL rvalid_timing observed=%b expected=%b", rvalid_o, prev_req);
            end
            if (rvalid_o === 1'b1) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_rvalid observed=response expected=none");
                end
                if (sb.size() != 0) begin
                    m_e = sb.pop_front();
                    checks++;
                    assert (rdata_o === m_e.data) else begin
                        errors++;
                        $error("FAIL %s observed=0x%0h expected=0x%0h", m_e.tag, rdata_o, m_e.data);
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [3:0] be, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp, input string tag);
        exp_t e;
        @(negedge clk);
        req_i   = 1'b1;
        we_i    = we;
        be_i    = be;
        addr_i  = {24'h0, addr};
        wdata_i = wd;
        e.tag   = tag;
        e.data  = we ? 32'h0 : exp;
        sb.push_back(e);
        @(negedge clk);
        req_i   = 1'b0;
        we_i    = 1'b0;
        be_i    = 4'h0;
        addr_i  = 32'h0;
        wdata_i = 32'h0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] wd, input string tag);
        bus(1'b1, 4'hF, addr, wd, 32'h0, tag);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        bus(1'b0, 4'hF, addr, 32'h0, exp, tag);
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            @(negedge clk);
            instret_i = 1'b1;
        end
        @(negedge clk);
        instret_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        check("rst_busy",   busy_o,   64'd0);
        check("rst_rvalid", rvalid_o, 64'd0);
        check("rst_rdata",  rdata_o,  64'd0);
        rd(8'h00, 32'h0, "rst_ctrl");
        rd(8'h04, 32'h0, "rst_ovf");
        rd(8'h10, 32'h0, "rst_r0_cyc_lo");
        rd(8'h14, 32'h0, "rst_r0_cyc_hi");
        rd(8'h18, 32'h0, "rst_r0_instr");
        rd(8'h1C, 32'h0, "rst_r0_entries");

        // Region 1 open for 101 counted cycles
        wr(8'h00, 32'h11, "start_r1");
        check("busy_run_r1", busy_o, 64'd1);
        repeat (99) @(negedge clk);
        wr(8'h00, 32'h02, "stop_r1");
        check("busy_after_stop", busy_o, 64'd0);
        rd(8'h20, 32'd101, "r1_cyc_lo");
        rd(8'h24, 32'd0,   "r1_cyc_hi");
        rd(8'h10, 32'd0,   "r0_cyc_lo_isolated");
        rd(8'h28, 32'd0,   "r1_instr");
        rd(8'h2C, 32'd1,   "r1_entries");
        @(negedge clk);
        check("rdata_hold",  rdata_o,  64'd1);
        check("rvalid_idle", rvalid_o, 64'd0);

        // Instret attribution across a region switch
        wr(8'h00, 32'h01, "start_r0");
        pulses(37);
        wr(8'h00, 32'h21, "switch_r2");
        pulses(5);
        rd(8'h00, 32'h21, "ctrl_run_r2");
        check("busy_run_r2", busy_o, 64'd1);
        wr(8'h00, 32'h02, "stop_r2");
        rd(8'h00, 32'h20, "ctrl_idle_r2");
        rd(8'h10, 32'd39, "r0_cyc_lo");
        rd(8'h18, 32'd37, "r0_instr");
        rd(8'h1C, 32'd1,  "r0_entries");
        rd(8'h30, 32'd10, "r2_cyc_lo");
        rd(8'h38, 32'd5,  "r2_instr");
        rd(8'h3C, 32'd1,  "r2_entries");
        rd(8'h20, 32'd101, "r1_cyc_lo_isolated");

        // 64-bit wrap of region 3
        @(negedge clk);
        dut.g_region[3].u_counter.r_cycles <= 64'hFFFF_FFFF_FFFF_FFFE;
        wr(8'h00, 32'h31, "start_r3");
        @(negedge clk);
        wr(8'h00, 32'h02, "stop_r3");
        rd(8'h40, 32'd1, "r3_cyc_lo_wrap");
        rd(8'h44, 32'd0, "r3_cyc_hi_wrap");
        rd(8'h04, 32'h8, "ovf_r3_set");
        wr(8'h04, 32'h8, "ovf_clear");
        rd(8'h04, 32'h0, "ovf_r3_cleared");

        // HI word comes from the snapshot taken at the LO read
        @(negedge clk);
        dut.g_region[3].u_counter.r_cycles <= 64'h0000_0007_FFFF_FFFF;
        rd(8'h40, 32'hFFFF_FFFF, "r3_cyc_lo_snap");
        rd(8'h44, 32'h7,         "r3_cyc_hi_snap");
        rd(8'h24, 32'h7,         "hi_snapshot_shared");

        // Writes that must leave the state untouched
        bus(1'b1, 4'h3, 8'h00, 32'h11, 32'h0, "start_be3");
        check("busy_be3", busy_o, 64'd0);
        wr(8'h00, 32'h51, "start_r5");
        check("busy_r5", busy_o, 64'd0);
        wr(8'h00, 32'h02, "stop_in_idle");
        wr(8'h00, 32'h13, "start_and_stop");
        check("busy_start_stop", busy_o, 64'd0);
        bus(1'b1, 4'h7, 8'h08, 32'h0, 32'h0, "clear_be7");
        rd(8'h00, 32'h30, "ctrl_unchanged");
        rd(8'h2C, 32'd1,  "r1_entries_unchanged");
        rd(8'h20, 32'd101, "r1_cyc_after_be7_clear");
        rd(8'h0C, 32'h0,  "unmapped_0c");
        rd(8'h50, 32'h0,  "region4_oob");

        // CLEAR zeroes everything and forces idle
        wr(8'h00, 32'h11, "start_r1_again");
        check("busy_before_clear", busy_o, 64'd1);
        wr(8'h08, 32'h0, "clear");
        check("busy_after_clear", busy_o, 64'd0);
        rd(8'h20, 32'd0, "r1_cyc_cleared");
        rd(8'h2C, 32'd0, "r1_entries_cleared");
        rd(8'h40, 32'd0, "r3_cyc_cleared");
        rd(8'h18, 32'd0, "r0_instr_cleared");

        // Asynchronous reset in the middle of a run
        wr(8'h00, 32'h21, "start_r2_pre_rst");
        repeat (5) @(negedge clk);
        rd(8'h00, 32'h21, "ctrl_pre_rst");
        #3;
        rst_ni = 1'b0;
        #1;
        check("arst_busy",   busy_o,   64'd0);
        check("arst_rvalid", rvalid_o, 64'd0);
        check("arst_rdata",  rdata_o,  64'd0);
        check("arst_r2_cyc", dut.g_region[2].u_counter.r_cycles, 64'd0);
        #3;
        rst_ni = 1'b1;
        wr(8'h00, 32'h21, "start_r2_post_rst");
        wr(8'h00, 32'h02, "stop_r2_post_rst");
        rd(8'h30, 32'd2, "r2_cyc_post_rst");
        rd(8'h3C, 32'd1, "r2_entries_post_rst");
        rd(8'h38, 32'd0, "r2_instr_post_rst");

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perf_region_ctrl.md
Name: perf_region_ctrl

Overview:
- Device-bus slave on the simple-system peripheral bus; same request/response protocol as the simulator control device.
- Firmware marks code regions, such as individual crypto kernels, by writing start and stop commands.
- Per region, the block accumulates elapsed cycles, retired instructions and entry counts.
- The testbench or firmware reads the counters back for profiling, which replaces ad-hoc CSR dumps.

Parameters:
- NumRegions, 4, number of profiled regions (1..8).
- CycleCntWidth, 64, per-region cycle accumulator width (33..64).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_i  in  1  bus request, single-cycle.
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- addr_i  in  32  byte address; only addr_i[7:0] is decoded.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- instret_i  in  1  one-cycle pulse per retired instruction.
- busy_o  out  1  a region is currently open.

Behaviour:
- Reset (async, active-low):
  - rvalid_o=0, rdata_o=0, busy_o=0.
  - All counters, overflow flags, the HI snapshot, active region and running flag cleared.
- Bus timing:
  - Every req_i gets rvalid_o=1 exactly one cycle later, for writes too; no back-pressure.
  - rdata_o is registered; it is 0 for writes, unmapped offsets and region index >= NumRegions.
  - Writes are accepted only when be_i==4'hF; otherwise the write is ignored but still acknowledged.
  - rdata_o holds its value while rvalid_o=0.
- Register map (offsets):
  - 0x00 CTRL:
    - Write: bit0 START, bit1 STOP, bits[6:4] REGION.
    - Read: bit0 running, bits[6:4] active region.
  - 0x04 OVF:
    - Read: bit r = sticky overflow of region r.
    - Write: 1-to-clear.
  - 0x08 CLEAR: any accepted write zeroes all counters and overflow flags and forces idle.
  - 0x10+16*r+0x0 CYC_LO: cycles[31:0]. Reading it latches cycles[CycleCntWidth-1:32] into a shared HI snapshot.
  - +0x4 CYC_HI: returns the snapshot, not the live counter. Zero-extended when CycleCntWidth<64.
  - +0x8 INSTR: 32-bit retired-instruction count.
  - +0xC ENTRIES: 32-bit count of region openings.
- States IDLE, RUN (running flag; busy_o = RUN):
  - IDLE + START(REGION=k, k<NumRegions): active=k, ENTRIES[k]++, go to RUN. Counting starts the cycle after the write.
  - RUN + START(k): switch regions. Old region stops counting that cycle, new region begins next cycle, ENTRIES[k]++.
  - START with REGION >= NumRegions: ignored entirely.
  - RUN + STOP: go to IDLE. The cycle of the write is still counted.
  - IDLE + STOP: no effect.
  - START and STOP both set: STOP wins.
  - CLEAR in the same cycle as a count or instret pulse: the clear wins.
- Counting in RUN:
  - cycles[active]+1 every cycle.
  - INSTR[active]+1 on each cycle with instret_i=1.
- Overflow: any counter wrapping to 0 wraps and sets OVF[active].
- Region isolation: CTRL accepts writes while in RUN; counters of non-active regions never change except via CLEAR.

Decomposition:
- Shared package perf_region_pkg holds:
  - register offset localparams (CTRL, OVF, CLEAR, REGION_BASE, REGION_STRIDE);
  - the CTRL field positions;
  - the state enum typedef (IDLE, RUN).
- One natural sub-module, perf_region_counter: one instance per region. It holds the cycles/instr/entries counters and the overflow flag, with inc_cyc/inc_instr/inc_entry/clear inputs and a count/ovf readout.

Test Plan:
- Reset then read 0x00, 0x04, 0x10..0x1C: every response has rvalid_o one cycle after req_i, and rdata=0.
- Write CTRL=0x11 (START region 1), idle 99 cycles, write CTRL=0x02: CYC_LO[1] is 100 + write-cycle accounting (exactly 101 by the rules above), ENTRIES[1]=1, busy_o low afterwards.
- In RUN on region 0, pulse instret_i 37 times, then START region 2 with 5 further pulses: INSTR[0]=37, INSTR[2]=5, ENTRIES[2]=1.
- Force region 3 cycles to 0xFFFF_FFFF_FFFF_FFFE via hierarchical deposit, run 3 cycles, read LO then HI: LO=1, HI=0, OVF=0x8; write OVF=0x8 and the read returns 0.
- Write with be_i=4'h3, START region 5 (NumRegions=4), and STOP in IDLE: state unchanged, all still acknowledged.
- Assert rst_ni asynchronously mid-RUN (not clock-aligned): outputs and counters go to 0 immediately; START after release counts from 0.
